// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and its datapath/memory.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic             ir_we;
    logic             mdr_we;
    logic             pc_we;
    logic             pc_src;
    logic             alusrc;
    logic [1:0]       aluop;
    logic             regwrite;
    logic             memtoreg;
    logic             retire;
    logic [CNT_W-1:0] instr_count;
    logic             trap;
    logic             trap_cause;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, mem_addr_sel,
        output ir_we, mdr_we, pc_we, pc_src,
        output alusrc, aluop, regwrite, memtoreg,
        output retire, instr_count, trap, trap_cause
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, mem_addr_sel,
        input  ir_we, mdr_we, pc_we, pc_src,
        input  alusrc, aluop, regwrite, memtoreg,
        input  retire, instr_count, trap, trap_cause
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset sequencer sharing one memory port.
// FETCH/DECODE/EXEC/MEM/WB with memory-timeout and illegal-opcode traps.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_ILL
    } op_e;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d, op_dec;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trap_q, trap_d;
    logic             cause_q, cause_d;

    logic       mem_req, mem_we, mem_addr_sel;
    logic       ir_we, mdr_we, pc_we, pc_src;
    logic       alusrc, regwrite, memtoreg, retire;
    logic [1:0] aluop;
    logic       timeout;

    always_comb begin
        case (bus.opcode)
            7'b0110011: op_dec = OP_R;
            7'b0010011: op_dec = OP_I;
            7'b0000011: op_dec = OP_LW;
            7'b0100011: op_dec = OP_SW;
            7'b1100011: op_dec = OP_BEQ;
            default:    op_dec = OP_ILL;
        endcase
    end

    assign timeout = (wait_q == WAIT_LAST) && !bus.mem_ready;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        trap_d       = trap_q;
        cause_d      = cause_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        alusrc       = 1'b0;
        aluop        = 2'd0;
        regwrite     = 1'b0;
        memtoreg     = 1'b0;
        retire       = 1'b0;

        unique case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = DECODE;
                end else if (timeout) begin
                    trap_d  = 1'b1;
                    cause_d = 1'b1;
                    state_d = TRAP;
                end
            end
            DECODE: begin
                op_d = op_dec;
                if (op_dec == OP_ILL) begin
                    trap_d  = 1'b1;
                    cause_d = 1'b0;
                    state_d = TRAP;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                unique case (op_q)
                    OP_R: begin
                        aluop   = 2'd2;
                        state_d = WB;
                    end
                    OP_I: begin
                        aluop   = 2'd2;
                        alusrc  = 1'b1;
                        state_d = WB;
                    end
                    OP_LW, OP_SW: begin
                        alusrc  = 1'b1;
                        state_d = MEM;
                    end
                    OP_BEQ: begin
                        aluop   = 2'd1;
                        pc_we   = bus.zero;
                        pc_src  = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    default: begin
                        trap_d  = 1'b1;
                        cause_d = 1'b0;
                        state_d = TRAP;
                    end
                endcase
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (op_q == OP_SW);
                alusrc       = 1'b1;
                if (bus.mem_ready) begin
                    if (op_q == OP_SW) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = WB;
                    end
                end else if (timeout) begin
                    trap_d  = 1'b1;
                    cause_d = 1'b1;
                    state_d = TRAP;
                end
            end
            WB: begin
                regwrite = 1'b1;
                memtoreg = (op_q == OP_LW);
                retire   = 1'b1;
                if (op_q == OP_R || op_q == OP_I) aluop = 2'd2;
                alusrc  = (op_q == OP_I);
                state_d = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Any cycle not stalled on memory restarts the wait count.
        wait_d = (mem_req && !bus.mem_ready) ? wait_q + 1'b1 : '0;
        cnt_d  = cnt_q + CNT_W'(retire);

        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_we        = 1'b0;
            mdr_we       = 1'b0;
            pc_we        = 1'b0;
            pc_src       = 1'b0;
            alusrc       = 1'b0;
            aluop        = 2'd0;
            regwrite     = 1'b0;
            memtoreg     = 1'b0;
            retire       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            op_q    <= OP_ILL;
            wait_q  <= '0;
            cnt_q   <= '0;
            trap_q  <= 1'b0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr_sel = mem_addr_sel;
    assign bus.ir_we        = ir_we;
    assign bus.mdr_we       = mdr_we;
    assign bus.pc_we        = pc_we;
    assign bus.pc_src       = pc_src;
    assign bus.alusrc       = alusrc;
    assign bus.aluop        = aluop;
    assign bus.regwrite     = regwrite;
    assign bus.memtoreg     = memtoreg;
    assign bus.retire       = retire;
    assign bus.instr_count  = cnt_q;
    assign bus.trap         = trap_q;
    assign bus.trap_cause   = cause_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus randomized instruction
// streams checked against an instruction-level timing/enable model.
module tb_multicycle_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multicycle_ctrl_if #(.CNT_W(CW)) bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    typedef struct {
        int          cycles;
        bit          retired;
        bit          trapped;
        logic        cause;
        int          ir_n, mdr_n, mdr_cyc, mwe_n, addr1_n;
        int          pcwe_n, pcbr_n, reg_n, rego_n, m2r_n;
        logic [1:0]  aluop;
        logic        alusrc;
        logic [CW-1:0] count;
    } obs_t;

    // Instruction classes: 0 R, 1 I, 2 lw, 3 sw, 4 beq, 5 illegal
    function automatic logic [6:0] opc_of(int c);
        case (c)
            0: return 7'b0110011;
            1: return 7'b0010011;
            2: return 7'b0000011;
            3: return 7'b0100011;
            4: return 7'b1100011;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int lat(int c, int wf, int wm);
        case (c)
            0, 1: return 4 + wf;
            2: return 5 + wf + wm;
            3: return 4 + wf + wm;
            default: return 3 + wf;
        endcase
    endfunction

    function automatic logic [1:0] exp_aluop(int c);
        return (c <= 1) ? 2'd2 : (c == 4) ? 2'd1 : 2'd0;
    endfunction

    // Memory model: each granted access is followed by the next wait budget.
    task automatic run_instr(input int c, input int wf, input int wm,
                             input bit z, output obs_t o);
        int waits;
        int after_ir;
        bit done;
        o = '{default: 0};
        waits = wf;
        after_ir = -1;
        done = 1'b0;
        bus.opcode = opc_of(c);
        bus.zero = z;
        for (int cyc = 1; cyc <= 30 && !done; cyc++) begin
            if (after_ir >= 0 && cyc > after_ir + 1) bus.opcode = 7'($urandom);
            if (bus.mem_req) bus.mem_ready = (waits == 0);
            else bus.mem_ready = 1'($urandom);
            #1;
            if (bus.mem_req && bus.mem_ready) waits = wm;
            else if (bus.mem_req) waits--;
            if (bus.ir_we) begin o.ir_n++; after_ir = cyc; end
            if (bus.mdr_we) begin o.mdr_n++; o.mdr_cyc = cyc; end
            if (bus.mem_we) o.mwe_n++;
            if (bus.mem_req && bus.mem_addr_sel) o.addr1_n++;
            if (bus.pc_we) o.pcwe_n++;
            if (bus.pc_we && bus.pc_src) o.pcbr_n++;
            if (bus.regwrite) o.reg_n++;
            if (bus.regwrite && !bus.retire) o.rego_n++;
            if (bus.memtoreg) o.m2r_n++;
            if (bus.retire) begin
                o.retired = 1'b1;
                o.cycles = cyc;
                o.aluop = bus.aluop;
                o.alusrc = bus.alusrc;
                done = 1'b1;
            end
            if (bus.trap) begin
                o.trapped = 1'b1;
                o.cause = bus.trap_cause;
                o.cycles = cyc;
                done = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        o.count = bus.instr_count;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = opc_of(0);
        bus.zero = 1'b0;
        #1;
        n_cmp++;
        if ({bus.mem_req, bus.mem_we, bus.ir_we, bus.mdr_we, bus.pc_we,
             bus.regwrite, bus.retire} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_gate: enables active during rst");
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.instr_count !== '0 || bus.trap !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: count=%0d trap=%b want 0/0",
                     bus.instr_count, bus.trap);
        end
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        n_cmp++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr_sel !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_fetch: mem_req=%b sel=%b want 1/0",
                     bus.mem_req, bus.mem_addr_sel);
        end
    endtask

    task automatic test_add();
        obs_t o;
        run_instr(0, 0, 0, 1'b0, o);
        exp_cnt = (exp_cnt + 1) % 16;
        n_cmp++;
        if (o.cycles !== 4 || o.reg_n !== 1 || o.rego_n !== 0) begin
            n_bad++;
            $display("FAIL add: lat=%0d reg=%0d stray=%0d want 4/1/0",
                     o.cycles, o.reg_n, o.rego_n);
        end
        n_cmp++;
        if (o.count !== CW'(exp_cnt) || o.aluop !== 2'd2) begin
            n_bad++;
            $display("FAIL add_count: count=%0d aluop=%0d want %0d/2",
                     o.count, o.aluop, exp_cnt);
        end
    endtask

    task automatic test_lw_wait();
        obs_t o;
        run_instr(2, 0, 2, 1'b0, o);
        exp_cnt = (exp_cnt + 1) % 16;
        n_cmp++;
        if (o.cycles !== 7 || o.mdr_cyc !== 6 || o.mdr_n !== 1) begin
            n_bad++;
            $display("FAIL lw_wait: lat=%0d mdr_cyc=%0d mdr=%0d want 7/6/1",
                     o.cycles, o.mdr_cyc, o.mdr_n);
        end
        n_cmp++;
        if (o.m2r_n !== 1 || o.addr1_n !== 3 || o.mwe_n !== 0) begin
            n_bad++;
            $display("FAIL lw_mem: m2r=%0d addr1=%0d we=%0d want 1/3/0",
                     o.m2r_n, o.addr1_n, o.mwe_n);
        end
    endtask

    task automatic test_beq();
        obs_t o;
        for (int k = 0; k < 2; k++) begin
            bit z;
            z = (k == 0);
            run_instr(4, 0, 0, z, o);
            exp_cnt = (exp_cnt + 1) % 16;
            n_cmp++;
            if (o.cycles !== 3 || o.pcwe_n !== 1 + int'(z)
                || o.pcbr_n !== int'(z)) begin
                n_bad++;
                $display("FAIL beq z=%0d: lat=%0d pcwe=%0d br=%0d want 3/%0d/%0d",
                         z, o.cycles, o.pcwe_n, o.pcbr_n, 1 + int'(z), int'(z));
            end
            n_cmp++;
            if (o.aluop !== 2'd1 || o.alusrc !== 1'b0) begin
                n_bad++;
                $display("FAIL beq_alu: aluop=%0d src=%b want 1/0",
                         o.aluop, o.alusrc);
            end
        end
    endtask

    task automatic test_illegal();
        obs_t o;
        int bad;
        run_instr(5, 0, 0, 1'b0, o);
        n_cmp++;
        if (!o.trapped || o.cycles !== 3 || o.cause !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal: trap=%b at=%0d cause=%b want 1/3/0",
                     o.trapped, o.cycles, o.cause);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = 1'($urandom);
            #1;
            if (bus.mem_req || bus.ir_we || bus.pc_we || !bus.trap) bad++;
            @(posedge clk);
            @(negedge clk);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL trap_absorb: %0d bad cycles want 0", bad);
        end
        do_reset();
        #1;
        n_cmp++;
        if (bus.trap !== 1'b0 || bus.mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL trap_rst: trap=%b mem_req=%b want 0/1",
                     bus.trap, bus.mem_req);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        int bad;
        bus.opcode = opc_of(0);
        bad = 0;
        for (int i = 0; i < TO; i++) begin
            bus.mem_ready = 1'b0;
            #1;
            if (bus.mem_req !== 1'b1 || bus.trap !== 1'b0) bad++;
            @(posedge clk);
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (bad !== 0 || bus.trap !== 1'b1 || bus.trap_cause !== 1'b1
            || bus.mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_timeout: early=%0d trap=%b cause=%b req=%b",
                     bad, bus.trap, bus.trap_cause, bus.mem_req);
        end
        do_reset();
        for (int i = 0; i < TO - 1; i++) begin
            bus.mem_ready = 1'b0;
            #1;
            @(posedge clk);
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.ir_we !== 1'b1) begin
            n_bad++;
            $display("FAIL late_ready: ir_we=%b want 1", bus.ir_we);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.trap !== 1'b0) begin
            n_bad++;
            $display("FAIL late_ready_trap: trap=%b want 0", bus.trap);
        end
        do_reset();
        run_instr(2, 1, 99, 1'b0, o);
        n_cmp++;
        if (!o.trapped || o.cause !== 1'b1 || o.cycles !== 4 + TO + 1) begin
            n_bad++;
            $display("FAIL mem_timeout: trap=%b cause=%b at=%0d want 1/1/%0d",
                     o.trapped, o.cause, o.cycles, 4 + TO + 1);
        end
        do_reset();
    endtask

    task automatic test_wrap();
        obs_t o;
        int lbad;
        lbad = 0;
        for (int i = 0; i < 17; i++) begin
            int wf, wm;
            wf = $urandom_range(0, TO - 1);
            wm = $urandom_range(0, TO - 1);
            run_instr(3, wf, wm, 1'($urandom), o);
            exp_cnt = (exp_cnt + 1) % 16;
            if (!o.retired || o.cycles !== lat(3, wf, wm)
                || o.mwe_n !== wm + 1) lbad++;
        end
        n_cmp++;
        if (lbad !== 0) begin
            n_bad++;
            $display("FAIL sw_stream: %0d bad instructions want 0", lbad);
        end
        n_cmp++;
        if (bus.instr_count !== CW'(exp_cnt) || exp_cnt !== 1) begin
            n_bad++;
            $display("FAIL wrap: count=%0d want 1", bus.instr_count);
        end
    endtask

    task automatic test_random();
        obs_t o;
        for (int i = 0; i < 40; i++) begin
            int c, wf, wm, ewm;
            bit z, mem;
            c = $urandom_range(0, 4);
            wf = $urandom_range(0, TO - 1);
            wm = $urandom_range(0, TO - 1);
            z = 1'($urandom);
            mem = (c == 2 || c == 3);
            ewm = mem ? wm : 0;
            run_instr(c, wf, wm, z, o);
            exp_cnt = (exp_cnt + 1) % 16;
            n_cmp++;
            if (!o.retired || o.cycles !== lat(c, wf, ewm)) begin
                n_bad++;
                $display("FAIL rnd_lat #%0d c=%0d: lat=%0d want %0d",
                         i, c, o.cycles, lat(c, wf, ewm));
            end
            n_cmp++;
            if (o.ir_n !== 1 || o.mdr_n !== int'(c == 2)
                || o.mwe_n !== (c == 3 ? wm + 1 : 0)
                || o.addr1_n !== (mem ? wm + 1 : 0)) begin
                n_bad++;
                $display("FAIL rnd_mem #%0d c=%0d: ir=%0d mdr=%0d we=%0d a1=%0d",
                         i, c, o.ir_n, o.mdr_n, o.mwe_n, o.addr1_n);
            end
            n_cmp++;
            if (o.pcwe_n !== 1 + int'(c == 4 && z)
                || o.pcbr_n !== int'(c == 4 && z)) begin
                n_bad++;
                $display("FAIL rnd_pc #%0d c=%0d z=%0d: pcwe=%0d br=%0d",
                         i, c, z, o.pcwe_n, o.pcbr_n);
            end
            n_cmp++;
            if (o.reg_n !== int'(c <= 2) || o.rego_n !== 0
                || o.m2r_n !== int'(c == 2)) begin
                n_bad++;
                $display("FAIL rnd_wb #%0d c=%0d: reg=%0d stray=%0d m2r=%0d",
                         i, c, o.reg_n, o.rego_n, o.m2r_n);
            end
            n_cmp++;
            if (o.aluop !== exp_aluop(c)
                || o.alusrc !== logic'(c == 1 || c == 3)) begin
                n_bad++;
                $display("FAIL rnd_alu #%0d c=%0d: aluop=%0d src=%b",
                         i, c, o.aluop, o.alusrc);
            end
            n_cmp++;
            if (o.count !== CW'(exp_cnt)) begin
                n_bad++;
                $display("FAIL rnd_count #%0d: count=%0d want %0d",
                         i, o.count, exp_cnt);
            end
        end
    endtask

    task automatic test_rst_mid();
        obs_t o;
        run_instr(0, 0, 0, 1'b0, o);
        bus.opcode = opc_of(3);
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'b1;
            #1;
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.mem_we !== 1'b0 || bus.mem_req !== 1'b0
            || bus.retire !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_gate: we=%b req=%b ret=%b want 0/0/0",
                     bus.mem_we, bus.mem_req, bus.retire);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        n_cmp++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr_sel !== 1'b0
            || bus.instr_count !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_fetch: req=%b sel=%b cnt=%0d want 1/0/0",
                     bus.mem_req, bus.mem_addr_sel, bus.instr_count);
        end
        run_instr(1, 0, 0, 1'b0, o);
        exp_cnt = (exp_cnt + 1) % 16;
        n_cmp++;
        if (o.cycles !== 4 || o.count !== CW'(exp_cnt)) begin
            n_bad++;
            $display("FAIL rst_mid_resume: lat=%0d cnt=%0d want 4/%0d",
                     o.cycles, o.count, exp_cnt);
        end
    endtask

    initial begin
        bus.opcode = 7'd0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_timeout();
        test_wrap();
        test_random();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
